// File: rtl/dmem_responder.sv
// Byte-addressable data memory responder with asynchronous read. Accesses that
// cross a word boundary are split into two cycles through a small IDLE/SPLIT FSM.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        StallMem,
  output logic        AccessErr
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   lobuf_q, lobuf_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [AW-1:0] w, w1;
  logic [1:0]    off;
  logic          legal_st, legal_ld, req_ok, do_st, do_ld, spanning;
  logic [3:0]    smask, we_lo, we_hi;
  logic [7:0]    be;
  logic [63:0]   wwin, rwin;
  logic [31:0]   lo_word, raw;
  logic          unused_ok;

  assign w   = Mem_WrAddr[AW+1:2];
  assign w1  = w + 1'b1;
  assign off = Mem_WrAddr[1:0];

  assign legal_st  = funct3M inside {3'b000, 3'b001, 3'b010};
  assign legal_ld  = funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign AccessErr = (MemWriteM & ~legal_st) | (MemReadM & ~legal_ld);

  assign req_ok = (MemWriteM | MemReadM) & ~AccessErr & ~reset;
  assign do_st  = req_ok & MemWriteM;
  assign do_ld  = req_ok & MemReadM & ~MemWriteM;

  assign spanning = ((funct3M[1:0] == 2'b01) && (off == 2'b11)) ||
                    ((funct3M[1:0] == 2'b10) && (off != 2'b00));

  // Two-word byte window: low half lands in word w, high half in word w+1.
  assign smask = (funct3M[1:0] == 2'b00) ? 4'h1 :
                 (funct3M[1:0] == 2'b01) ? 4'h3 : 4'hF;
  assign be    = {4'b0, smask} << off;
  assign wwin  = {32'b0, Mem_WrData} << {off, 3'b000};

  assign lo_word = (state_q == SPLIT) ? lobuf_q : mem_q[w];
  assign rwin    = {mem_q[w1], lo_word} >> {off, 3'b000};
  assign raw     = rwin[31:0];

  assign StallMem = (state_q == IDLE) && spanning && (do_st || do_ld);

  always_comb begin
    state_d  = state_q;
    lobuf_d  = lobuf_q;
    we_lo    = '0;
    we_hi    = '0;
    ReadData = '0;
    case (state_q)
      IDLE: begin
        if (do_st) we_lo = be[3:0];
        if (StallMem) begin
          state_d = SPLIT;
          if (do_ld) lobuf_d = mem_q[w];
        end
      end
      SPLIT: begin
        if (do_st) we_hi = be[7:4];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // No result while the first half of a split load is still being gathered.
    if (do_ld && !StallMem) begin
      case (funct3M)
        3'b000:  ReadData = {{24{raw[7]}}, raw[7:0]};
        3'b001:  ReadData = {{16{raw[15]}}, raw[15:0]};
        3'b010:  ReadData = raw;
        3'b100:  ReadData = {24'b0, raw[7:0]};
        3'b101:  ReadData = {16'b0, raw[15:0]};
        default: ReadData = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lobuf_q <= '0;
    end else begin
      state_q <= state_d;
      lobuf_q <= lobuf_d;
    end
  end

  // Byte enables are already cleared by reset through req_ok.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_lo[b]) mem_q[w][8*b +: 8]  <= wwin[8*b +: 8];
      if (we_hi[b]) mem_q[w1][8*b +: 8] <= wwin[32+8*b +: 8];
    end
  end

  assign unused_ok = ^{Mem_WrAddr[31:AW+2], rwin[63:32]};

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, is the number of 32-bit words in the internal data array and SHALL be a power of two, at least 4.
REQ-002 Parameter AW, default 6, is the word-index width and SHALL equal log2(DEPTH_WORDS).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port MemWriteM, input, 1 bit: store request in the memory stage.
REQ-006 Port MemReadM, input, 1 bit: load request in the memory stage.
REQ-007 Port funct3M, input, 3 bits: access size and sign.
REQ-008 Port Mem_WrAddr, input, 32 bits: byte address.
REQ-009 Port Mem_WrData, input, 32 bits: store data, right-justified.
REQ-010 Port ReadData, output, 32 bits: extended load result.
REQ-011 Port StallMem, output, 1 bit: the pipeline SHALL hold all M-stage inputs stable while this is high.
REQ-012 Port AccessErr, output, 1 bit: illegal funct3 on an active request.

Function
REQ-013 Word index SHALL be Mem_WrAddr[AW+1:2]; upper address bits are ignored, and the index wraps modulo DEPTH_WORDS.
REQ-014 The byte offset, off, SHALL be Mem_WrAddr[1:0]; storage is little-endian.
REQ-015 The array read SHALL be asynchronous, so ReadData is valid in the same cycle as the request; writes SHALL occur on the rising clock edge.
REQ-016 Legal stores: 000 sb, 001 sh, 010 sw; only the addressed bytes SHALL change.
REQ-017 Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; lb and lh sign-extend, lbu and lhu zero-extend.
REQ-018 AccessErr SHALL be combinational: it is 1 when (MemWriteM or MemReadM) and funct3M is illegal for that direction. The request is then ignored: no write, ReadData equals 0, StallMem equals 0.
REQ-019 If MemWriteM and MemReadM are both 1, the store SHALL be performed and ReadData SHALL be 0.
REQ-020 When no legal load is active, ReadData SHALL be 0.
REQ-021 A spanning access is a halfword with off equal to 3, or a word with off not equal to 0; all other accesses complete in one cycle with StallMem equal to 0.
REQ-022 The FSM SHALL have two states, IDLE and SPLIT; a one-word latch LoBuf holds the low bytes of a split load.
REQ-023 IDLE with a legal spanning access: StallMem equals 1 (combinational). The access touches word w for bytes off..3. A store writes those bytes at the clock edge; a load captures them into LoBuf. Next state is SPLIT.
REQ-024 SPLIT: StallMem equals 0. The access touches word (w+1) modulo DEPTH_WORDS for the remaining bytes starting at byte 0. A store writes them. A load drives ReadData as the extension of {new bytes, LoBuf bytes}. Next state is IDLE.
REQ-025 If MemWriteM and MemReadM are both 0 in SPLIT, the FSM SHALL return to IDLE with no array write.
REQ-026 Total latency: 1 cycle for a non-spanning access, 2 cycles for a spanning access. No back-to-back SPLIT is possible.

Reset
REQ-027 While reset is high at a clock edge: state becomes IDLE and LoBuf becomes 0; the array SHALL NOT be written or cleared.
REQ-028 During reset, StallMem SHALL be 0 and ReadData SHALL be 0 regardless of other inputs.
REQ-029 Reset asserted in SPLIT SHALL abort the access: the second half of a split store is not written, and no load result is produced.

Verification
REQ-030 sw 0xA1B2C3D4 at addr 0x10, then lw 0x10 -> ReadData 0xA1B2C3D4 in the same cycle, StallMem 0.
REQ-031 After REQ-030: lb 0x13 -> 0xFFFFFFA1; lbu 0x13 -> 0x000000A1; lh 0x12 -> 0xFFFFA1B2; sb 0x55 at 0x11, then lw 0x10 -> 0xA1B255D4.
REQ-032 Word 0x10 = 0x44332211 and word 0x14 = 0x88776655; lw 0x12 -> cycle 1 StallMem 1, cycle 2 StallMem 0 and ReadData 0x66554433.
REQ-033 sh 0xBEEF at 0x0F in a 64-word array -> byte 0x0F = 0xEF, byte 0x10 = 0xBE, 2 cycles; sw 0x12345678 at 0xFE (word 63/0 wrap) -> bytes 0xFE, 0xFF = 0x78, 0x56 and bytes 0x00, 0x01 = 0x34, 0x12.
REQ-034 funct3M 011 with MemReadM 1 -> AccessErr 1, ReadData 0, StallMem 0; funct3M 100 with MemWriteM 1 -> AccessErr 1 and the array is unchanged.
REQ-035 Start a spanning sw at 0x21 and assert reset in the SPLIT cycle -> bytes 0x21-0x23 updated, byte 0x24 unchanged, state IDLE, StallMem 0.
